xcvr_bringup_seq: RTL and testbench

//  Reset/bring-up sequencer for the QSFP and SDI transceiver subsystem. Holds system reset through

---
 rtl/xcvr_seq_pkg.sv | 18 +
 rtl/xcvr_bringup_seq_if.sv | 35 +++
 rtl/sync2.sv | 27 ++
 rtl/xcvr_bringup_seq.sv | 177 +++++++++++++++++
 tb/tb_xcvr_bringup_seq.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/xcvr_seq_pkg.sv
// Shared types and widths for the transceiver bring-up sequencer.
//   seq_state_t : encoded sequencer state, also driven out on seq_state
//   TMR_W       : width of the shared timer, loss filter and heartbeat counters
//   RETRY_W     : width of the recovery counter
package xcvr_seq_pkg;

    localparam int unsigned TMR_W   = 27;
    localparam int unsigned RETRY_W = 4;

    typedef enum logic [2:0] {
        POR_WAIT  = 3'd0,
        LOCK_WAIT = 3'd1,
        RUN       = 3'd2,
        RECOVER   = 3'd3,
        FAIL      = 3'd4
    } seq_state_t;

endpackage

// File: rtl/xcvr_bringup_seq_if.sv
// Board-side bundle of the bring-up sequencer.
//   pll_locked, retry_req        : asynchronous inputs from the transceivers / pushbutton
//   system_reset_n, qsfp_rstn    : resets driven to the transceiver system and QSFP module
//   links_ready, seq_fail,
//   seq_state, retry_cnt,
//   lock_lost, heartbeat         : status, also used for the user LEDs
// master = the sequencer, slave = the transceiver/board side.
interface xcvr_bringup_seq_if #(
    parameter int unsigned NUM_PLL = 3
) ();

    logic [NUM_PLL-1:0]                  pll_locked;
    logic                                retry_req;
    logic                                system_reset_n;
    logic                                qsfp_rstn;
    logic                                links_ready;
    logic [2:0]                          seq_state;
    logic [xcvr_seq_pkg::RETRY_W-1:0]    retry_cnt;
    logic [NUM_PLL-1:0]                  lock_lost;
    logic                                seq_fail;
    logic                                heartbeat;

    modport master (
        input  pll_locked, retry_req,
        output system_reset_n, qsfp_rstn, links_ready, seq_state,
               retry_cnt, lock_lost, seq_fail, heartbeat
    );

    modport slave (
        output pll_locked, retry_req,
        input  system_reset_n, qsfp_rstn, links_ready, seq_state,
               retry_cnt, lock_lost, seq_fail, heartbeat
    );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both stages
//   d     : asynchronous input
//   q     : synchronized output, two clk cycles of latency
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/xcvr_bringup_seq.sv
// Reset/bring-up sequencer for the QSFP and SDI transceivers: holds the
// transceiver reset through power-on, waits for every ATX PLL to lock,
// declares the links ready, and re-runs the sequence on lock loss with a
// bounded number of retries before parking in FAIL.
//   clk_50     : 50 MHz free-running clock
//   cpu_resetn : asynchronous active-low board reset
//   bus        : board-side bundle (locks, retry button, resets, status/LEDs)
module xcvr_bringup_seq
    import xcvr_seq_pkg::*;
#(
    parameter int unsigned NUM_PLL      = 3,
    parameter int unsigned POR_CYCLES   = 32'h0700_0000,
    parameter int unsigned RST_HOLD     = 1000,
    parameter int unsigned LOCK_TIMEOUT = 50_000_000,
    parameter int unsigned LOSS_FILTER  = 1024,
    parameter int unsigned MAX_RETRY    = 7
) (
    input  logic               clk_50,
    input  logic               cpu_resetn,
    xcvr_bringup_seq_if.master bus
);

    // Every count must fit the 27-bit timer, and the retry limit its counter.
    if (NUM_PLL < 1 ||
        POR_CYCLES   < 1 || POR_CYCLES   > (1 << TMR_W) ||
        RST_HOLD     < 1 || RST_HOLD     > (1 << TMR_W) ||
        LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > (1 << TMR_W) ||
        LOSS_FILTER  < 1 || LOSS_FILTER  > (1 << TMR_W) ||
        MAX_RETRY > 15) begin : g_param_err
        $error("xcvr_bringup_seq: parameter out of range");
    end

    localparam logic [TMR_W-1:0]   POR_LAST  = TMR_W'(POR_CYCLES - 1);
    localparam logic [TMR_W-1:0]   HOLD_LAST = TMR_W'(RST_HOLD - 1);
    localparam logic [TMR_W-1:0]   TMO_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]   LOSS_LAST = TMR_W'(LOSS_FILTER - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [RETRY_W-1:0] RETRY_SAT = '1;

    logic [NUM_PLL-1:0] pll_s;
    logic               rr_s;
    logic               rr_d;

    seq_state_t         st;
    logic [TMR_W-1:0]   tmr;
    logic [TMR_W-1:0]   loss_cnt;
    logic [TMR_W-1:0]   hb_cnt;
    logic [RETRY_W-1:0] retry_cnt;
    logic [NUM_PLL-1:0] lock_lost;
    logic               system_reset_n;
    logic               qsfp_rstn;
    logic               links_ready;
    logic               seq_fail;

    logic               all_locked_c;
    logic               rr_rise_c;
    logic               fault_c;

    sync2 #(.WIDTH(NUM_PLL)) u_sync_lock (
        .clk   (clk_50),
        .rst_n (cpu_resetn),
        .d     (bus.pll_locked),
        .q     (pll_s)
    );

    sync2 #(.WIDTH(1)) u_sync_retry (
        .clk   (clk_50),
        .rst_n (cpu_resetn),
        .d     (bus.retry_req),
        .q     (rr_s)
    );

    assign all_locked_c = &pll_s;
    assign rr_rise_c    = rr_s & ~rr_d;

    // Lock timeout in LOCK_WAIT or filtered lock loss in RUN; a lock arriving
    // on the timeout cycle wins.
    assign fault_c = !all_locked_c &&
                     ((st == LOCK_WAIT && tmr == TMO_LAST) ||
                      (st == RUN && loss_cnt == LOSS_LAST));

    always_ff @(posedge clk_50 or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            st             <= POR_WAIT;
            tmr            <= '0;
            loss_cnt       <= '0;
            hb_cnt         <= '0;
            retry_cnt      <= '0;
            lock_lost      <= '0;
            rr_d           <= 1'b0;
            system_reset_n <= 1'b0;
            qsfp_rstn      <= 1'b0;
            links_ready    <= 1'b0;
            seq_fail       <= 1'b0;
        end else begin
            hb_cnt <= hb_cnt + TMR_W'(1);
            rr_d   <= rr_s;

            if (st == RUN) begin
                lock_lost <= lock_lost | ~pll_s;
            end

            if (fault_c) begin
                links_ready <= 1'b0;
                loss_cnt    <= '0;
                tmr         <= '0;
                if (retry_cnt == RETRY_MAX) begin
                    st             <= FAIL;
                    seq_fail       <= 1'b1;
                    system_reset_n <= 1'b1;
                end else begin
                    st             <= RECOVER;
                    system_reset_n <= 1'b0;
                    retry_cnt      <= (retry_cnt == RETRY_SAT) ? retry_cnt
                                                               : retry_cnt + RETRY_W'(1);
                end
            end else begin
                unique case (st)
                    POR_WAIT: begin
                        if (tmr == POR_LAST) begin
                            st             <= LOCK_WAIT;
                            tmr            <= '0;
                            system_reset_n <= 1'b1;
                            qsfp_rstn      <= 1'b1;
                        end else begin
                            tmr <= tmr + TMR_W'(1);
                        end
                    end
                    LOCK_WAIT: begin
                        if (all_locked_c) begin
                            st          <= RUN;
                            links_ready <= 1'b1;
                            loss_cnt    <= '0;
                        end else begin
                            tmr <= tmr + TMR_W'(1);
                        end
                    end
                    RUN: begin
                        loss_cnt <= all_locked_c ? '0 : loss_cnt + TMR_W'(1);
                    end
                    RECOVER: begin
                        if (tmr == HOLD_LAST) begin
                            st             <= LOCK_WAIT;
                            tmr            <= '0;
                            system_reset_n <= 1'b1;
                        end else begin
                            tmr <= tmr + TMR_W'(1);
                        end
                    end
                    FAIL: begin
                        // Operator retry: fresh retry budget, then a normal recovery.
                        if (rr_rise_c) begin
                            st             <= RECOVER;
                            tmr            <= '0;
                            retry_cnt      <= '0;
                            seq_fail       <= 1'b0;
                            system_reset_n <= 1'b0;
                        end
                    end
                    default: begin
                        st <= POR_WAIT;
                    end
                endcase
            end
        end
    end

    assign bus.system_reset_n = system_reset_n;
    assign bus.qsfp_rstn      = qsfp_rstn;
    assign bus.links_ready    = links_ready;
    assign bus.seq_state      = st;
    assign bus.retry_cnt      = retry_cnt;
    assign bus.lock_lost      = lock_lost;
    assign bus.seq_fail       = seq_fail;
    assign bus.heartbeat      = hb_cnt[TMR_W-1];

endmodule

// File: tb/tb_xcvr_bringup_seq.sv
// Bench for xcvr_bringup_seq with shortened timing parameters.
module tb_xcvr_bringup_seq;
    import xcvr_seq_pkg::*;

    localparam int unsigned NPLL = 3;
    localparam int unsigned POR  = 100;
    localparam int unsigned HOLD = 10;
    localparam int unsigned TMO  = 50;
    localparam int unsigned LOSS = 8;
    localparam int unsigned MAXR = 2;

    logic clk_50 = 1'b0;
    logic cpu_resetn;

    always #10 clk_50 = ~clk_50;

    xcvr_bringup_seq_if #(.NUM_PLL(NPLL)) bus ();

    xcvr_bringup_seq #(
        .NUM_PLL      (NPLL),
        .POR_CYCLES   (POR),
        .RST_HOLD     (HOLD),
        .LOCK_TIMEOUT (TMO),
        .LOSS_FILTER  (LOSS),
        .MAX_RETRY    (MAXR)
    ) dut (
        .clk_50     (clk_50),
        .cpu_resetn (cpu_resetn),
        .bus        (bus)
    );

    // Expected state transition: new state, cycles since the previous
    // transition or stimulus mark (-1 = don't care), and outputs on entry.
    typedef struct {
        logic [2:0] st;
        int         dly;
        logic [3:0] rc;
        logic       srn;
        logic       qrn;
        logic       lr;
        logic       sf;
    } exp_t;

    exp_t       exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic [2:0] prev_st  = 3'd0;
    int         since    = 0;

    task automatic expect_tr(input logic [2:0] st, input int dly, input logic [3:0] rc,
                             input logic srn, input logic qrn, input logic lr, input logic sf);
        exp_t e;
        e.st = st; e.dly = dly; e.rc = rc;
        e.srn = srn; e.qrn = qrn; e.lr = lr; e.sf = sf;
        exp_q.push_back(e);
    endtask

    // One clock: sample at the falling edge and score any state change.
    task automatic tick();
        exp_t e;
        @(negedge clk_50);
        since++;
        if (bus.seq_state !== prev_st) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: state %0d -> %0d with nothing expected",
                         prev_st, bus.seq_state);
            end else begin
                e = exp_q.pop_front();
                if (bus.seq_state !== e.st) begin
                    failures++;
                    $display("FAIL sb_state: got %0d expected %0d", bus.seq_state, e.st);
                end
                if (e.dly >= 0) begin
                    checks++;
                    if (since != e.dly) begin
                        failures++;
                        $display("FAIL sb_latency: state %0d after %0d cycles expected %0d",
                                 e.st, since, e.dly);
                    end
                end
                checks++;
                if ({bus.retry_cnt, bus.system_reset_n, bus.qsfp_rstn, bus.links_ready, bus.seq_fail}
                    !== {e.rc, e.srn, e.qrn, e.lr, e.sf}) begin
                    failures++;
                    $display("FAIL sb_outputs: state %0d got rc=%0d srn=%b qrn=%b lr=%b sf=%b expected rc=%0d srn=%b qrn=%b lr=%b sf=%b",
                             e.st, bus.retry_cnt, bus.system_reset_n, bus.qsfp_rstn, bus.links_ready,
                             bus.seq_fail, e.rc, e.srn, e.qrn, e.lr, e.sf);
                end
            end
            prev_st = bus.seq_state;
            since   = 0;
        end
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: %0d expected transitions still pending", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({bus.system_reset_n, bus.qsfp_rstn, bus.links_ready, bus.seq_fail, bus.heartbeat} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: srn/qrn/lr/sf/hb=%b expected 00000",
                     {bus.system_reset_n, bus.qsfp_rstn, bus.links_ready, bus.seq_fail, bus.heartbeat});
        end
        checks++;
        if (bus.seq_state !== 3'd0) begin
            failures++;
            $display("FAIL reset_state: got %0d expected 0", bus.seq_state);
        end
        checks++;
        if ({bus.retry_cnt, bus.lock_lost} !== 7'b0) begin
            failures++;
            $display("FAIL reset_status: retry_cnt=%0d lock_lost=%b expected 0/000",
                     bus.retry_cnt, bus.lock_lost);
        end
    endtask

    task automatic test_bringup();
        cpu_resetn = 1'b1;
        since      = 0;
        expect_tr(LOCK_WAIT, int'(POR), 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_tr(RUN,       1,         4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_idle(int'(POR) + 20, "bringup");
    endtask

    task automatic test_glitch();
        bus.pll_locked = 3'b101;
        repeat (5) tick();
        bus.pll_locked = 3'b111;
        repeat (15) tick();
        checks++;
        if ({bus.seq_state, bus.links_ready} !== {3'd2, 1'b1}) begin
            failures++;
            $display("FAIL glitch_run: state=%0d links_ready=%b expected 2/1",
                     bus.seq_state, bus.links_ready);
        end
        checks++;
        if ({bus.lock_lost, bus.retry_cnt} !== {3'b010, 4'd0}) begin
            failures++;
            $display("FAIL glitch_status: lock_lost=%b retry_cnt=%0d expected 010/0",
                     bus.lock_lost, bus.retry_cnt);
        end
    endtask

    task automatic test_loss_recover();
        bus.pll_locked = 3'b011;
        since          = 0;
        expect_tr(RECOVER,   int'(LOSS) + 2, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_tr(LOCK_WAIT, int'(HOLD),     4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_tr(RUN,       3,              4'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (20) tick();
        bus.pll_locked = 3'b111;
        wait_idle(40, "loss");
        checks++;
        if (bus.lock_lost !== 3'b110) begin
            failures++;
            $display("FAIL loss_sticky: lock_lost=%b expected 110", bus.lock_lost);
        end
    endtask

    task automatic test_timeout_fail();
        bus.pll_locked = 3'b110;
        expect_tr(POR_WAIT, -1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cpu_resetn = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.lock_lost !== 3'b000) begin
            failures++;
            $display("FAIL por_clear: lock_lost=%b expected 000", bus.lock_lost);
        end
        cpu_resetn = 1'b1;
        since      = 0;
        expect_tr(LOCK_WAIT, int'(POR),  4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_tr(RECOVER,   int'(TMO),  4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_tr(LOCK_WAIT, int'(HOLD), 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_tr(RECOVER,   int'(TMO),  4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_tr(LOCK_WAIT, int'(HOLD), 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_tr(FAIL,      int'(TMO),  4'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_idle(int'(POR + 3 * TMO + 2 * HOLD) + 20, "timeout");
        repeat (30) tick();
        checks++;
        if ({bus.seq_state, bus.seq_fail, bus.system_reset_n, bus.links_ready, bus.retry_cnt}
            !== {3'd4, 1'b1, 1'b1, 1'b0, 4'd2}) begin
            failures++;
            $display("FAIL fail_hold: state=%0d sf=%b srn=%b lr=%b rc=%0d expected 4/1/1/0/2",
                     bus.seq_state, bus.seq_fail, bus.system_reset_n, bus.links_ready, bus.retry_cnt);
        end
    endtask

    task automatic test_retry();
        bus.pll_locked = 3'b111;
        bus.retry_req  = 1'b1;
        since          = 0;
        expect_tr(RECOVER,   3,          4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_tr(LOCK_WAIT, int'(HOLD), 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_tr(RUN,       1,          4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) tick();
        bus.retry_req = 1'b0;
        wait_idle(40, "retry");
        // A button press while running must be ignored.
        bus.retry_req = 1'b1;
        repeat (3) tick();
        bus.retry_req = 1'b0;
        repeat (10) tick();
        checks++;
        if ({bus.seq_state, bus.retry_cnt, bus.links_ready} !== {3'd2, 4'd0, 1'b1}) begin
            failures++;
            $display("FAIL retry_ignored: state=%0d rc=%0d lr=%b expected 2/0/1",
                     bus.seq_state, bus.retry_cnt, bus.links_ready);
        end
    endtask

    task automatic test_reset_mid();
        bus.pll_locked = 3'b110;
        since          = 0;
        expect_tr(RECOVER, int'(LOSS) + 2, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_idle(30, "mid_recover");
        bus.pll_locked = 3'b111;
        repeat (4) tick();
        expect_tr(POR_WAIT, -1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        cpu_resetn = 1'b0;
        #1;
        checks++;
        if ({bus.seq_state, bus.system_reset_n, bus.qsfp_rstn, bus.links_ready, bus.seq_fail,
             bus.retry_cnt, bus.lock_lost, bus.heartbeat} !== 15'b0) begin
            failures++;
            $display("FAIL async_reset: state=%0d srn=%b qrn=%b lr=%b sf=%b rc=%0d ll=%b hb=%b expected all 0",
                     bus.seq_state, bus.system_reset_n, bus.qsfp_rstn, bus.links_ready, bus.seq_fail,
                     bus.retry_cnt, bus.lock_lost, bus.heartbeat);
        end
        tick();
        tick();
        cpu_resetn = 1'b1;
        since      = 0;
        expect_tr(LOCK_WAIT, int'(POR), 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_tr(RUN,       1,         4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_idle(int'(POR) + 20, "rebringup");
    endtask

    initial begin
        bus.pll_locked = 3'b111;
        bus.retry_req  = 1'b0;
        cpu_resetn     = 1'b1;
        #5 cpu_resetn  = 1'b0;
        test_reset();
        test_bringup();
        test_glitch();
        test_loss_recover();
        test_timeout_fail();
        test_retry();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
